store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer directly downstream of the store stage. It accepts the store stage's address / write-data / write-enable triple and queues up to DEPTH word stores in a FIFO. It drains them in order to the data-memory port over a req/ack handshake. Loads in the memory stage can read buffered data through a combinational forwarding lookup, so a load does not read stale memory.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, store data width (one word)

Reset is synchronous and active-high; one clock.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  store request from store stage (its write_enable)
- st_address  in  ADDR_WIDTH  byte address (ALU base + sign-extended offset)
- st_write_data  in  DATA_WIDTH  word to store (rt contents)
- st_ready  out  1  buffer can accept a store this cycle
- ld_address  in  ADDR_WIDTH  load address for forwarding lookup
- ld_hit  out  1  a buffered store matches ld_address
- ld_data  out  DATA_WIDTH  data of youngest matching entry; 0 when no hit
- mem_req  out  1  head entry presented to memory
- mem_addr  out  ADDR_WIDTH  head entry address
- mem_wdata  out  DATA_WIDTH  head entry data
- mem_ack  in  1  memory accepts head entry this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- misaligned  out  1  sticky: a store with st_address[1:0] != 0 was dropped

## Operation
- Storage: DEPTH entries {addr, data, valid}. Write pointer wr_ptr and read pointer rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- Push: st_valid && st_ready && st_address[1:0]==0.
  - Writes the entry at wr_ptr, sets its valid bit, increments wr_ptr.
- Misaligned: st_valid && st_ready && st_address[1:0]!=0.
  - The store is not written; misaligned is set and held until reset.
- st_ready = (count < DEPTH), computed from registered count only. There is no same-cycle bypass of a pop when full.
  - If st_valid is high while st_ready is low, the store is ignored; upstream must hold it.
- Drain FSM, two states:
  - IDLE: mem_req=0. Go to ISSUE on the edge where count becomes nonzero.
  - ISSUE: mem_req=1; mem_addr and mem_wdata come from entry rd_ptr.
  - On mem_ack in ISSUE: clear valid[rd_ptr], increment rd_ptr. Stay in ISSUE if post-update count > 0, else go to IDLE.
- mem_ack is ignored in IDLE.
- mem_addr and mem_wdata stay stable while mem_req=1 and mem_ack=0.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Forwarding is combinational:
  - Compare ld_address[ADDR_WIDTH-1:2] against every valid entry's addr[ADDR_WIDTH-1:2].
  - The youngest match (closest to wr_ptr-1) wins.
  - A store being pushed in the same cycle is not visible to the lookup.
  - An entry popped in the same cycle is still visible until the edge.
- Arithmetic: pointers and count are unsigned. Addresses are compared as word addresses; data is passed unmodified.

## Timing
- Reset values, applied at the first edge with reset=1:
  - count=0, empty=1, st_ready=1, mem_req=0, misaligned=0, ld_hit=0, ld_data=0.
  - Pointers are 0, all valid bits are 0, and entry addr/data are cleared, so mem_addr=0 and mem_wdata=0.
  - FSM is in IDLE.
- Reset mid-operation discards all queued stores. No further mem_req is issued for them; mem_req is 0 the cycle after the reset edge.
- Push-to-memory latency: a store pushed at edge N is on mem_req/mem_addr at cycle N+1, when the buffer was empty before N.
- Throughput: one pop per cycle when mem_ack is held high. With mem_ack held high, mem_req deasserts the cycle after the final pop.
- Forwarding: ld_hit and ld_data have zero-cycle latency from ld_address.
- Full: after DEPTH pushes with no ack, st_ready=0 in the following cycle. st_ready returns to 1 the cycle after the first ack.
- Reset has priority over push, pop and the misaligned flag in the same cycle.

## Test plan
- Single store: push addr 0x0000_0010, data 0xDEAD_BEEF into an empty buffer.
  - Required: mem_req=1 with that addr/data the next cycle.
  - ack -> empty=1 and mem_req=0 the cycle after.
- Fill and backpressure: 4 pushes with mem_ack=0.
  - Required: count=4, st_ready=0; a 5th st_valid is ignored.
  - One ack -> st_ready=1 next cycle. Drain order matches push order.
- Forwarding: push 0x20→0x1111_1111 then 0x20→0x2222_2222.
  - ld_address 0x22 -> ld_hit=1, ld_data=0x2222_2222.
  - ld_address 0x24 -> ld_hit=0, ld_data=0.
- Misaligned: push addr 0x0000_0013.
  - Required: count unchanged, misaligned=1 and held until reset.
- Simultaneous push and pop with count=2 and mem_ack=1: count stays 2.
  - Run 6 cycles of continuous push and ack to wrap both pointers.
  - Check FIFO ordering across the wrap.
- Reset mid-drain: count=3, assert reset for one cycle.
  - Required: count=0, mem_req=0, misaligned=0. No stale entry is issued afterwards.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues aligned word stores, drains them in order
// over a req/ack memory port, and forwards buffered data to loads.
module store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [ADDR_WIDTH-1:0]    st_address,
  input  logic [DATA_WIDTH-1:0]    st_write_data,
  output logic                     st_ready,
  input  logic [ADDR_WIDTH-1:0]    ld_address,
  output logic                     ld_hit,
  output logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     mem_req,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     misaligned
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic                  r_misaligned;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_bad_align;
  logic                  w_pop;
  logic                  w_ld_hit;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [PTR_W-1:0]      w_idx;

  // Readiness comes from the registered count only; a same-cycle pop does not free a slot.
  assign w_ready     = r_count < CNT_W'(DEPTH);
  assign w_accept    = st_valid && w_ready;
  assign w_push      = w_accept && (st_address[1:0] == 2'b00);
  assign w_bad_align = w_accept && (st_address[1:0] != 2'b00);
  assign w_pop       = (r_state == S_ISSUE) && mem_ack;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Drain FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Drain FSM: next state follows the post-update occupancy.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_count_nxt != '0) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_pop && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Drain FSM: outputs.
  always_comb begin
    mem_req = 1'b0;
    if (r_state == S_ISSUE) mem_req = 1'b1;
  end

  // FIFO storage, pointers, occupancy and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= '0;
      r_misaligned <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_addr[r_wr_ptr]  <= st_address;
        r_data[r_wr_ptr]  <= st_write_data;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_bad_align) r_misaligned <= 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Scan oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    w_idx     = r_rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (r_valid[w_idx] &&
          (r_addr[w_idx][ADDR_WIDTH-1:2] == ld_address[ADDR_WIDTH-1:2])) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data[w_idx];
      end
    end
  end

  assign ld_hit     = w_ld_hit;
  assign ld_data    = w_ld_data;
  assign st_ready   = w_ready;
  assign count      = r_count;
  assign empty      = (r_count == '0);
  assign misaligned = r_misaligned;
  assign mem_addr   = r_addr[r_rd_ptr];
  assign mem_wdata  = r_data[r_rd_ptr];

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stimulus with a scoreboard of expected
// memory writes, checked against the handshake as the buffer drains.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_address;
  logic [DW-1:0] st_write_data;
  logic          st_ready;
  logic [AW-1:0] ld_address;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [2:0]    count;
  logic          empty;
  logic          misaligned;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int   n_total = 0;
  int   n_bad   = 0;
  int   m_cnt   = 0;
  logic m_issue = 1'b0;
  logic m_mis   = 1'b0;
  logic m_push, m_pop, m_bad;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_address(st_address), .st_write_data(st_write_data),
    .st_ready(st_ready),
    .ld_address(ld_address), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .empty(empty), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid      = 1'b1;
    st_address    = a;
    st_write_data = d;
    cyc();
    st_valid      = 1'b0;
  endtask

  // Reference model: checks per-cycle status, scores drained entries in order.
  always @(negedge clk) begin
    chk("mem_req",    64'(mem_req),    64'(m_issue));
    chk("st_ready",   64'(st_ready),   64'(m_cnt < DEPTH));
    chk("count",      64'(count),      64'(m_cnt));
    chk("empty",      64'(empty),      64'(m_cnt == 0));
    chk("misaligned", 64'(misaligned), 64'(m_mis));
    if (reset) begin
      m_cnt   = 0;
      m_issue = 1'b0;
      m_mis   = 1'b0;
      sb.delete();
    end else begin
      m_push = st_valid && (m_cnt < DEPTH) && (st_address[1:0] == 2'b00);
      m_bad  = st_valid && (m_cnt < DEPTH) && (st_address[1:0] != 2'b00);
      m_pop  = m_issue && mem_ack;
      if (m_pop) begin
        if (sb.size() == 0) begin
          chk("sb_underrun", 64'(0), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("drain_addr",  64'(mem_addr),  64'(e.a));
          chk("drain_wdata", 64'(mem_wdata), 64'(e.d));
        end
      end
      if (m_push) sb.push_back('{a: st_address, d: st_write_data});
      if (m_bad) m_mis = 1'b1;
      m_cnt   = m_cnt + int'(m_push) - int'(m_pop);
      m_issue = (m_cnt != 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_address = '0; st_write_data = '0;
    ld_address = '0; mem_ack = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_count",    64'(count),     64'(0));
    chk("rst_empty",    64'(empty),     64'(1));
    chk("rst_ready",    64'(st_ready),  64'(1));
    chk("rst_req",      64'(mem_req),   64'(0));
    chk("rst_mis",      64'(misaligned),64'(0));
    chk("rst_ld_hit",   64'(ld_hit),    64'(0));
    chk("rst_ld_data",  64'(ld_data),   64'(0));
    chk("rst_mem_addr", 64'(mem_addr),  64'(0));
    chk("rst_mem_wd",   64'(mem_wdata), 64'(0));

    // Single store and one-cycle issue latency.
    push(32'h0000_0010, 32'hDEAD_BEEF);
    chk("single_req",   64'(mem_req),   64'(1));
    chk("single_addr",  64'(mem_addr),  64'h10);
    chk("single_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("single_empty", 64'(empty),   64'(1));
    chk("single_noreq", 64'(mem_req), 64'(0));

    // Fill with no ack, then backpressure.
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    chk("full_count", 64'(count),    64'(4));
    chk("full_ready", 64'(st_ready), 64'(0));
    push(32'h200, 32'h5555_5555);
    chk("full_ignored", 64'(count), 64'(4));
    chk("full_head",    64'(mem_addr), 64'h100);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("ack_ready", 64'(st_ready), 64'(1));
    chk("ack_count", 64'(count),    64'(3));
    mem_ack = 1'b1; repeat (3) cyc(); mem_ack = 1'b0;
    chk("fill_drained", 64'(empty), 64'(1));

    // Forwarding: youngest match wins, word-address compare.
    push(32'h20, 32'h1111_1111);
    push(32'h20, 32'h2222_2222);
    ld_address = 32'h22; #1;
    chk("fwd_hit",  64'(ld_hit),  64'(1));
    chk("fwd_data", 64'(ld_data), 64'h2222_2222);
    ld_address = 32'h24; #1;
    chk("fwd_miss_hit",  64'(ld_hit),  64'(0));
    chk("fwd_miss_data", 64'(ld_data), 64'(0));
    ld_address = 32'h20; mem_ack = 1'b1; #1;
    chk("fwd_popping_hit",  64'(ld_hit),  64'(1));
    chk("fwd_popping_data", 64'(ld_data), 64'h2222_2222);
    cyc();
    chk("fwd_one_left", 64'(ld_data), 64'h2222_2222);
    cyc(); mem_ack = 1'b0;
    chk("fwd_gone_hit",  64'(ld_hit),  64'(0));
    chk("fwd_gone_data", 64'(ld_data), 64'(0));
    st_valid = 1'b1; st_address = 32'h40; st_write_data = 32'h4444_4444;
    ld_address = 32'h40; #1;
    chk("fwd_same_cycle_push", 64'(ld_hit), 64'(0));
    cyc(); st_valid = 1'b0;
    chk("fwd_after_push_hit",  64'(ld_hit),  64'(1));
    chk("fwd_after_push_data", 64'(ld_data), 64'h4444_4444);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;

    // Misaligned store is dropped and flagged until reset.
    push(32'h0000_0013, 32'h9999_9999);
    chk("mis_count", 64'(count),      64'(0));
    chk("mis_flag",  64'(misaligned), 64'(1));
    repeat (3) cyc();
    chk("mis_held",  64'(misaligned), 64'(1));

    // Simultaneous push and pop across pointer wrap.
    push(32'h50, 32'hB000_0000);
    push(32'h54, 32'hB000_0001);
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      st_valid = 1'b1; st_address = 32'h60 + 32'(i * 4); st_write_data = 32'hC000_0000 + 32'(i);
      cyc();
      chk("pp_count", 64'(count), 64'(2));
    end
    st_valid = 1'b0;
    cyc(); cyc(); mem_ack = 1'b0;
    chk("pp_empty", 64'(empty), 64'(1));

    // Reset mid-drain discards queued stores.
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i * 4), 32'hD000_0000 + 32'(i));
    chk("pre_rst_count", 64'(count), 64'(3));
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mid_rst_count", 64'(count),      64'(0));
    chk("mid_rst_req",   64'(mem_req),    64'(0));
    chk("mid_rst_mis",   64'(misaligned), 64'(0));
    chk("mid_rst_addr",  64'(mem_addr),   64'(0));
    mem_ack = 1'b1;
    repeat (4) begin
      cyc();
      chk("post_rst_noreq", 64'(mem_req), 64'(0));
    end
    mem_ack = 1'b0;
    cyc();
    chk("sb_left", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
